// File: rtl/mcp_mux_buf_if.sv
// rtl/mcp_mux_buf_if.sv - producer/consumer bundle for the multi-channel MCP mux buffer
//
// Purpose: groups the per-channel write side and the shared output side of
// mcp_mux_buf so the design and its environment connect through one port.
// Signals:
//   asend   [NCH]     per-channel write request
//   adatain [NCH*DW]  per-channel data, channel i at [i*DW +: DW]
//   aready  [NCH]     channel i can accept a word this cycle
//   bload             consumer accepts / permits reload of the output register
//   bdata   [DW]      output word
//   bchan   [CW]      source channel of bdata
//   bvalid            bdata/bchan hold a valid word
//   ovf     [NCH]     sticky per-channel overflow flags
//   ovf_clr           clears all ovf bits
// Modports: slave = design view, master = environment view.

interface mcp_mux_buf_if #(
    parameter int DW  = 8,
    parameter int NCH = 4
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]    asend;
    logic [NCH*DW-1:0] adatain;
    logic [NCH-1:0]    aready;
    logic              bload;
    logic [DW-1:0]     bdata;
    logic [CW-1:0]     bchan;
    logic              bvalid;
    logic [NCH-1:0]    ovf;
    logic              ovf_clr;

    modport slave (
        input  asend, adatain, bload, ovf_clr,
        output aready, bdata, bchan, bvalid, ovf
    );

    modport master (
        output asend, adatain, bload, ovf_clr,
        input  aready, bdata, bchan, bvalid, ovf
    );
endinterface

// File: rtl/mcp_mux_buf.sv
// rtl/mcp_mux_buf.sv - per-channel FIFOs drained round-robin into one tagged output register
//
// Purpose: NCH producers push words (send/ready) into private FIFOs of depth
// DEPTH; a round-robin arbiter moves one word per cycle into a holding
// register (load/valid) tagged with its source channel.
// Ports:
//   clk  - single clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - mcp_mux_buf_if.slave (asend/adatain/aready, bload/bdata/bchan/bvalid, ovf/ovf_clr)

module mcp_mux_buf #(
    parameter int DW    = 8,
    parameter int NCH   = 4,
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    mcp_mux_buf_if.slave bus
);
    localparam int CW   = $clog2(NCH);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [DW-1:0]   mem_q    [NCH][DEPTH];
    logic [AW-1:0]   wr_ptr_q [NCH];
    logic [AW-1:0]   rd_ptr_q [NCH];
    logic [CNTW-1:0] count_q  [NCH];
    logic [CNTW-1:0] count_d  [NCH];
    logic [CW-1:0]   rr_q, rr_d;
    logic [NCH-1:0]  ovf_q, ovf_d;
    logic            bvalid_q, bvalid_d;
    logic [DW-1:0]   bdata_q, bdata_d;
    logic [CW-1:0]   bchan_q, bchan_d;

    logic [NCH-1:0]  aready;
    logic [NCH-1:0]  push;
    logic [NCH-1:0]  pop;
    logic [NCH-1:0]  drop;
    logic            fill;
    logic            found;
    logic [CW-1:0]   grant;
    logic [CW-1:0]   arb_idx;

    // Readiness comes from the registered count only, so a full FIFO refuses
    // a write even when it is being popped in the same cycle.
    always_comb begin
        aready = '0;
        for (int i = 0; i < NCH; i++) begin
            aready[i] = !rst && (count_q[i] < CNTW'(DEPTH));
        end
        push = bus.asend & aready;
        drop = bus.asend & ~aready & {NCH{!rst}};
    end

    // Search upward from the round-robin pointer, wrapping at NCH.
    always_comb begin
        found   = 1'b0;
        grant   = '0;
        arb_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            arb_idx = CW'((int'(rr_q) + k) % NCH);
            if (!found && (count_q[arb_idx] != '0)) begin
                found = 1'b1;
                grant = arb_idx;
            end
        end
    end

    always_comb begin
        fill     = !bvalid_q || bus.bload;
        pop      = '0;
        rr_d     = rr_q;
        bvalid_d = bvalid_q;
        bdata_d  = bdata_q;
        bchan_d  = bchan_q;
        for (int i = 0; i < NCH; i++) begin
            pop[i]     = fill && found && (grant == CW'(i));
            count_d[i] = count_q[i] + CNTW'(push[i]) - CNTW'(pop[i]);
        end
        if (fill) begin
            if (found) begin
                bvalid_d = 1'b1;
                bdata_d  = mem_q[grant][rd_ptr_q[grant]];
                bchan_d  = grant;
                rr_d     = (int'(grant) == NCH - 1) ? '0 : grant + 1'b1;
            end else begin
                // Nothing to send: drop valid but keep the last word/tag visible.
                bvalid_d = 1'b0;
            end
        end
        // A new overflow in the same cycle survives a clear.
        ovf_d = (bus.ovf_clr ? '0 : ovf_q) | drop;
    end

    // Storage array carries no reset; only pointers/counts define its contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst && push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= bus.adatain[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_q     <= '0;
            ovf_q    <= '0;
            bvalid_q <= 1'b0;
            bdata_q  <= '0;
            bchan_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                count_q[i] <= count_d[i];
            end
            rr_q     <= rr_d;
            ovf_q    <= ovf_d;
            bvalid_q <= bvalid_d;
            bdata_q  <= bdata_d;
            bchan_q  <= bchan_d;
        end
    end

    assign bus.aready = aready;
    assign bus.bvalid = bvalid_q;
    assign bus.bdata  = bdata_q;
    assign bus.bchan  = bchan_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: doc/mcp_mux_buf.md
Name: mcp_mux_buf

Overview:
- Single-clock, multi-channel successor to the single-word MCP send/load handshake block.
- NCH independent producers each push words using send/ready semantics into a per-channel FIFO of depth DEPTH.
- A round-robin arbiter drains the FIFOs into one output holding register using load/valid semantics, tagged with the source channel.
- Sits upstream of a clock-domain crossing block so that several sources can share one crossing.

Parameters:
- DW, 8, data word width in bits.
- NCH, 4, number of input channels (≥2).
- DEPTH, 4, per-channel FIFO depth (power of two, ≥2).
- CW, $clog2(NCH), channel-id width (derived, not overridden).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- asend  in  NCH  per-channel write request.
- adatain  in  NCH*DW  per-channel data; channel i occupies bits [i*DW +: DW].
- aready  out  NCH  channel i can accept a word this cycle.
- bload  in  1  consumer accepts/permits reload of output register.
- bdata  out  DW  output word.
- bchan  out  CW  source channel of bdata.
- bvalid  out  1  bdata/bchan hold a valid word.
- ovf  out  NCH  sticky per-channel overflow flag.
- ovf_clr  in  1  clears all ovf bits.

Behaviour:
- Reset:
  - While rst=1: writes are ignored and aready=0.
  - After release: all FIFOs are empty, aready all 1, bvalid=0, bdata=0, bchan=0, ovf=0, RR pointer=0.
  - Reset mid-operation discards all stored words and the output register contents.
- Write:
  - Accept on posedge when asend[i] && aready[i].
  - aready[i] = !rst && count[i] < DEPTH, decoded from registered state only.
  - There is no same-cycle bypass: a full FIFO rejects a write even if it is popped that cycle.
- Overflow:
  - asend[i] && !aready[i] (rst=0) drops the word and sets ovf[i].
  - ovf_clr clears all bits; a set in the same cycle wins over the clear.
- Output fill:
  - fill = !bvalid || bload.
  - On posedge with fill:
    - If any FIFO is non-empty, grant the first non-empty channel searching upward from the RR pointer (wrapping). Pop its head; bdata<=head, bchan<=grant, bvalid<=1; pointer <= (grant+1) mod NCH.
    - If all FIFOs are empty, bvalid<=0; bdata/bchan retain their values.
- Hold: while bvalid && !bload, bdata/bchan/bvalid stay stable and no FIFO is popped.
- Latency: word accepted at edge E appears on bdata after edge E+1 (bvalid in cycle E+2), provided the output register is free and the channel wins arbitration.
- Throughput: one word per cycle with bload held high. A channel can be written and popped in the same cycle.
- Capacity: DEPTH words per channel plus one in the output register.
- Ordering: per-channel order is preserved. Across channels the order is round-robin, which is starvation-free: a non-empty channel waits at most NCH-1 grants.
- Pointer arithmetic: count is CW-independent, log2(DEPTH)+1 bits. Read/write pointers wrap modulo DEPTH.

Test Plan (DW=8, NCH=4, DEPTH=4):
1. Single word: ch2 sends 0xA5 at edge E, bload=1 → bvalid=1 in cycle E+2 with bdata=0xA5, bchan=2; bvalid=0 the following cycle.
2. Round-robin:
   - All channels send 0x10..0x13 in one cycle, bload=1 → consecutive outputs (bchan,bdata) = (0,0x10), (1,0x11), (2,0x12), (3,0x13).
   - Then ch3 and ch0 send together → ch0 then ch3.
3. Full/overflow:
   - bload=0; ch1 sends 0x01..0x06 on consecutive cycles → 0x01 in output register, 0x02..0x05 in FIFO, aready[1]=0 when 0x06 is presented, ovf[1]=1, 0x06 dropped.
   - Then bload=1 → bdata 0x01..0x05 in order, aready[1] back to 1.
4. Hold: bvalid=1 with bdata=0x3C, bchan=1, bload=0 for 10 cycles → outputs unchanged and the FIFO count is unchanged, while other channels still accept writes.
5. ovf clear: ovf=0b0010.
   - ovf_clr together with a new ch1 overflow → ovf stays 0b0010.
   - ovf_clr alone → 0b0000.
6. Reset mid-operation: 3 words queued on ch0 plus bvalid=1, pulse rst for one cycle → bvalid=0, aready=0b1111 after release, no stale words emitted, next send on ch3 output with bchan=3.
